// File: rtl/noc_vc_buffer_if.sv
// Flit handshake bundle between an upstream link, the VC buffer and the downstream switch.
// The slave modport is the buffer's view; the master modport is the view of whoever drives it.
interface noc_vc_buffer_if #(
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int VC_WIDTH         = 3,
    parameter int DATA_WIDTH       = 256
);
    logic                        i_valid;
    logic                        i_ready;
    logic [VC_WIDTH-1:0]         i_vc;
    logic [DATA_WIDTH-1:0]       i_data;
    logic                        i_tail;
    logic                        o_valid;
    logic                        o_ready;
    logic [VC_WIDTH-1:0]         o_vc;
    logic [DATA_WIDTH-1:0]       o_data;
    logic                        o_tail;
    logic [VIRTUAL_CHANNELS-1:0] o_vc_empty;

    modport master (
        output i_valid, i_vc, i_data, i_tail, o_ready,
        input  i_ready, o_valid, o_vc, o_data, o_tail, o_vc_empty
    );

    modport slave (
        input  i_valid, i_vc, i_data, i_tail, o_ready,
        output i_ready, o_valid, o_vc, o_data, o_tail, o_vc_empty
    );
endinterface

// File: rtl/noc_vc_buffer.sv
// Per-virtual-channel input buffer for a NoC router port.
// Each VC owns an independent FIFO; a round-robin arbiter with packet lock drains them
// onto one output, so a packet's flits are never interleaved with another VC's flits.
module noc_vc_buffer #(
    parameter int VIRTUAL_CHANNELS = 2,
    parameter int VC_WIDTH         = 3,
    parameter int DATA_WIDTH       = 256,
    parameter int DEPTH            = 4
) (
    input  logic           clk,
    input  logic           rst,
    noc_vc_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // IDLE searches round-robin, HOLD freezes a stalled selection, LOCK pins a VC mid-packet
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD,
        ARB_LOCK
    } arb_state_t;

    // Each entry stores {tail, payload}
    logic [DATA_WIDTH:0]         mem    [VIRTUAL_CHANNELS][DEPTH];
    logic [PTR_W-1:0]            wr_ptr [VIRTUAL_CHANNELS];
    logic [PTR_W-1:0]            rd_ptr [VIRTUAL_CHANNELS];
    logic [CNT_W-1:0]            count  [VIRTUAL_CHANNELS];
    logic [VIRTUAL_CHANNELS-1:0] vc_empty;
    logic [VIRTUAL_CHANNELS-1:0] vc_full;
    logic [VIRTUAL_CHANNELS-1:0] push_en;
    logic [VIRTUAL_CHANNELS-1:0] pop_en;

    arb_state_t                  state;
    logic [VC_WIDTH-1:0]         frozen_vc;
    logic [VC_WIDTH-1:0]         rr_ptr;
    logic [VC_WIDTH-1:0]         sel_vc;
    logic                        sel_valid;
    logic [DATA_WIDTH:0]         head;
    logic                        in_ready;
    logic                        transfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic int wrap_index(input int idx);
        return (idx >= VIRTUAL_CHANNELS) ? idx - VIRTUAL_CHANNELS : idx;
    endfunction

    // Input acceptance depends only on the addressed VC's fill level, never on i_valid or a same-cycle pop
    always_comb begin
        in_ready = 1'b0;
        push_en  = '0;
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            vc_full[v] = (count[v] == CNT_W'(DEPTH));
            if (bus.i_vc == VC_WIDTH'(v) && !vc_full[v]) begin
                in_ready = 1'b1;
            end
        end
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            push_en[v] = bus.i_valid && in_ready && !rst && (bus.i_vc == VC_WIDTH'(v));
        end
    end

    // Pick the VC to present: the frozen one while holding or locked, otherwise first non-empty from rr_ptr
    always_comb begin
        sel_vc    = '0;
        sel_valid = 1'b0;
        if (state == ARB_IDLE) begin
            for (int k = 0; k < VIRTUAL_CHANNELS; k++) begin
                for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                    if (!sel_valid && !vc_empty[v] && v == wrap_index(int'(rr_ptr) + k)) begin
                        sel_vc    = VC_WIDTH'(v);
                        sel_valid = 1'b1;
                    end
                end
            end
        end else begin
            sel_vc = frozen_vc;
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                if (frozen_vc == VC_WIDTH'(v)) begin
                    sel_valid = !vc_empty[v];
                end
            end
        end
    end

    // Head-of-line mux and output drive; payload fields read as zero whenever nothing is offered
    always_comb begin
        head = '0;
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            if (sel_vc == VC_WIDTH'(v)) begin
                head = mem[v][rd_ptr[v]];
            end
        end
        transfer = sel_valid && bus.o_ready;
        pop_en   = '0;
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            pop_en[v] = transfer && (sel_vc == VC_WIDTH'(v));
        end
        bus.i_ready    = in_ready;
        bus.o_valid    = sel_valid;
        bus.o_vc       = sel_valid ? sel_vc : '0;
        bus.o_data     = sel_valid ? head[DATA_WIDTH-1:0] : '0;
        bus.o_tail     = sel_valid && head[DATA_WIDTH];
        bus.o_vc_empty = vc_empty;
    end

    // Flit storage has no reset; validity is tracked entirely by the pointers and counters
    always_ff @(posedge clk) begin
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            if (push_en[v]) begin
                mem[v][wr_ptr[v]] <= {bus.i_tail, bus.i_data};
            end
        end
    end

    // Per-VC pointers, occupancy and registered empty flags; push+pop on one VC leaves the count alone
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            vc_empty <= '1;
        end else begin
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                if (push_en[v]) begin
                    wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                end
                if (pop_en[v]) begin
                    rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                end
                if (push_en[v] && !pop_en[v]) begin
                    count[v]    <= count[v] + CNT_W'(1);
                    vc_empty[v] <= 1'b0;
                end else if (!push_en[v] && pop_en[v]) begin
                    count[v]    <= count[v] - CNT_W'(1);
                    vc_empty[v] <= (count[v] == CNT_W'(1));
                end
            end
        end
    end

    // Arbiter FSM: a tail transfer releases the output and advances rr past the served VC
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            frozen_vc <= '0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            if (head[DATA_WIDTH]) begin
                state  <= ARB_IDLE;
                rr_ptr <= (sel_vc == VC_WIDTH'(VIRTUAL_CHANNELS - 1)) ? '0 : sel_vc + VC_WIDTH'(1);
            end else begin
                state     <= ARB_LOCK;
                frozen_vc <= sel_vc;
            end
        end else if (sel_valid && state == ARB_IDLE) begin
            state     <= ARB_HOLD;
            frozen_vc <= sel_vc;
        end
    end

endmodule
